spi_trim_bank: RTL and testbench
================================

SPI_TRIM_BANK -- requirements
Module: spi_trim_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of trim registers (1..64).
REQ-002 SHALL have parameter REG_W, default 8, width in bits of each trim register (1..16).
REQ-003 SHALL have parameter RESET_TRIM, default 0, REG_W-bit reset value of every register.
REQ-004 SHALL have port clk  input  1  system clock; the only clock; SPI pins are oversampled on it.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-007 SHALL have port i_cs_n  input  1  SPI chip select, active low.
REQ-008 SHALL have port i_mosi  input  1  SPI data in, MSB first.
REQ-009 SHALL have port o_miso  output  1  SPI data out, MSB first.
REQ-010 SHALL have port o_miso_oe  output  1  MISO output enable, high while synchronized cs_n is low.
REQ-011 SHALL have port o_trim  output  NUM_REGS*REG_W  active registers; register k at bits [k*REG_W +: REG_W].
REQ-012 SHALL have port o_reg_pointer  output  clog2(NUM_REGS) (min 1)  last valid address accessed.
REQ-013 SHALL have port o_frame_err  output  1  one-cycle pulse on an aborted frame.
REQ-014 SHALL have port o_addr_err  output  1  one-cycle pulse on an out-of-range address.

Function
REQ-015 SHALL pass i_sclk, i_cs_n and i_mosi through 2-flop synchronizers each; clk SHALL be at least 4x sclk.
REQ-016 SHALL sample MOSI on the synchronized sclk rising edge and update o_miso on the synchronized falling edge.
REQ-017 SHALL use a frame of 8 command bits followed by REG_W data bits; cmd[7:6] is the opcode and cmd[5:0] is the address.
REQ-018 Opcodes SHALL be: 00 read active; 01 write shadow; 10 commit all shadows to active (data ignored); 11 read shadow.
REQ-019 SHALL keep one shadow and one active register per address; only opcode 10 SHALL change o_trim, and all registers SHALL update in the same clk cycle.
REQ-020 SHALL use an FSM with states IDLE -> CMD (cs_n falls) -> DATA (8th bit) -> DONE (last data bit) -> IDLE (cs_n rises).
REQ-021 In IDLE and while cs_n is high, o_miso SHALL be 0.
REQ-022 For reads, o_miso SHALL drive the selected register MSB first, starting on the falling edge after the 8th command bit.
REQ-023 A write or commit SHALL take effect at most 4 clk cycles after the raw sclk rising edge of the final data bit, without waiting for cs_n to rise.
REQ-024 In DONE, extra sclk edges SHALL be ignored and o_miso SHALL be 0.
REQ-025 If cs_n rises in CMD or DATA, the block SHALL pulse o_frame_err for 1 cycle, return to IDLE, and leave shadow, active and pointer unchanged.
REQ-026 If address >= NUM_REGS: a write SHALL be dropped, a read SHALL return all-0, the pointer SHALL be unchanged, and o_addr_err SHALL pulse once at the end of the command phase.
REQ-027 Commit SHALL ignore the address field and SHALL NOT raise o_addr_err.
REQ-028 o_reg_pointer SHALL update to the address at the end of the command phase for opcodes 00, 01 and 11 with a valid address.
REQ-029 A cs_n fall while in DONE or IDLE SHALL always start a fresh frame with the bit counter at 0.

Reset
REQ-030 When rst_n is low, all shadow and active registers SHALL be RESET_TRIM, and o_reg_pointer, o_miso, o_miso_oe, o_frame_err and o_addr_err SHALL be 0, and FSM=IDLE.
REQ-031 Reset asserted mid-frame SHALL abort the frame silently (no o_frame_err); the next frame SHALL need a new cs_n fall.
REQ-032 The synchronizer flops SHALL reset to sclk=0, cs_n=1, mosi=0.

Verification
REQ-033 Write shadow 0x41 to reg 3, then read active reg 3 -> MISO returns RESET_TRIM; then read shadow reg 3 -> MISO returns 0x41; o_trim unchanged.
REQ-034 Write 0xA5 to reg 2 and 0x3C to reg 7, then commit -> o_trim[23:16]=0xA5 and [63:56]=0x3C in the same cycle, within 4 clk of the last sclk edge; o_reg_pointer=7.
REQ-035 Raise cs_n after 11 of 16 bits of a write to reg 1 -> one o_frame_err pulse; shadow and active reg 1 unchanged; the next full frame succeeds.
REQ-036 Write to address 9 with NUM_REGS=8 -> o_addr_err pulse; no register changes; a read of address 9 returns 0x00.
REQ-037 Send 20 sclk pulses in one frame -> the first 16 bits act; the extra 4 bits are ignored with MISO=0.
REQ-038 Assert rst_n low during the DATA phase -> all outputs at reset values and no error pulse; NUM_REGS=5, REG_W=12 build passes REQ-033/034 with 20-bit frames.

Source files
------------

// File: rtl/spi_trim_bank.sv
// Purpose: SPI-slave (mode 0) bank of shadow/active trim registers, with a commit command that updates every active register at once.
// Latency: a write or commit lands 3 clk cycles after the raw sclk rising edge of the final data bit (2-flop sync + edge detect).
// Backpressure: none; the SPI master paces all traffic, and clk must run at least 4x sclk.
//
// Ports:
//   clk, rst_n        system clock and asynchronous active-low reset
//   i_sclk, i_cs_n    SPI clock and chip select (asynchronous, oversampled on clk)
//   i_mosi, o_miso    SPI data, MSB first; o_miso_oe follows synchronized cs_n
//   o_trim            active registers, register k at [k*REG_W +: REG_W]
//   o_reg_pointer     last valid address accessed by a read or write
//   o_frame_err       1-cycle pulse when cs_n rises in the middle of a frame
//   o_addr_err        1-cycle pulse when an out-of-range address is decoded
//
// Frame format: 8 command bits {opcode[1:0], addr[5:0]}, then REG_W data bits.
//   00 read active, 01 write shadow, 10 commit shadows to active, 11 read shadow.

module spi_trim_bank #(
  parameter int               NUM_REGS   = 8,
  parameter int               REG_W      = 8,
  parameter logic [REG_W-1:0] RESET_TRIM = '0,
  localparam int              PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_sclk,
  input  logic                      i_cs_n,
  input  logic                      i_mosi,
  output logic                      o_miso,
  output logic                      o_miso_oe,
  output logic [NUM_REGS*REG_W-1:0] o_trim,
  output logic [PTR_W-1:0]          o_reg_pointer,
  output logic                      o_frame_err,
  output logic                      o_addr_err
);

  localparam logic [1:0] OP_RD_ACT = 2'b00;
  localparam logic [1:0] OP_WR_SHD = 2'b01;
  localparam logic [1:0] OP_COMMIT = 2'b10;
  localparam logic [1:0] OP_RD_SHD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t state;

  // Synchronizers and edge detection
  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_q;
  logic       cs_q;
  logic [1:0] warm_cnt;

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;
  logic mosi_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      warm_cnt  <= 2'd0;
    end else begin
      sclk_sync <= {sclk_sync[0], i_sclk};
      cs_sync   <= {cs_sync[0], i_cs_n};
      mosi_sync <= {mosi_sync[0], i_mosi};
      sclk_q    <= sclk_sync[1];
      cs_q      <= cs_sync[1];
      if (warm_cnt != 2'd3) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  assign mosi_bit  = mosi_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_q;
  assign sclk_fall = ~sclk_sync[1] & sclk_q;
  assign cs_rise   = cs_sync[1] & ~cs_q;
  // The cs synchronizer resets to "deselected". If cs_n is already low when
  // reset lifts, the pipeline would show a spurious falling edge. warm_cnt
  // masks fall detection until the pipeline holds the real pin level, so a
  // frame interrupted by reset needs a genuine new cs_n fall.
  assign cs_fall   = ~cs_sync[1] & cs_q & (warm_cnt == 2'd3);

  // Register storage
  logic [REG_W-1:0] shadow [NUM_REGS];
  logic [REG_W-1:0] active [NUM_REGS];

  always_comb begin
    o_trim = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      o_trim[k*REG_W +: REG_W] = active[k];
    end
  end

  // Frame datapath
  logic [4:0]       bit_cnt;
  logic [6:0]       cmd_sr;
  logic [REG_W-1:0] rx_sr;
  logic [REG_W-1:0] tx_sr;
  logic [1:0]       op_q;
  logic [PTR_W-1:0] idx_q;
  logic             addr_ok_q;
  logic [PTR_W-1:0] ptr_prev;

  // The command byte and data word are finalised from the bit arriving on
  // the current edge, so the last bit is acted on with no extra cycle.
  logic [7:0]       cmd_next;
  logic [PTR_W-1:0] idx_next;
  logic             addr_ok_next;
  logic [REG_W-1:0] data_next;
  logic [REG_W-1:0] rd_val;

  assign cmd_next     = {cmd_sr, mosi_bit};
  assign idx_next     = cmd_next[PTR_W-1:0];
  assign addr_ok_next = ({1'b0, cmd_next[5:0]} < 7'(NUM_REGS));

  always_comb begin
    data_next    = rx_sr << 1;
    data_next[0] = mosi_bit;
  end

  // Read data is captured at the end of the command phase; out-of-range
  // reads and non-read opcodes shift out zeros.
  always_comb begin
    rd_val = '0;
    if (addr_ok_next) begin
      if (cmd_next[7:6] == OP_RD_ACT) begin
        rd_val = active[idx_next];
      end else if (cmd_next[7:6] == OP_RD_SHD) begin
        rd_val = shadow[idx_next];
      end
    end
  end

  // Frame FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      cmd_sr        <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      op_q          <= OP_RD_ACT;
      idx_q         <= '0;
      addr_ok_q     <= 1'b0;
      ptr_prev      <= '0;
      o_reg_pointer <= '0;
      o_miso        <= 1'b0;
      o_frame_err   <= 1'b0;
      o_addr_err    <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow[k] <= RESET_TRIM;
        active[k] <= RESET_TRIM;
      end
    end else begin
      o_frame_err <= 1'b0;
      o_addr_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          o_miso <= 1'b0;
          if (cs_fall) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
            cmd_sr  <= '0;
          end
        end

        ST_CMD: begin
          o_miso <= 1'b0;
          if (cs_rise) begin
            state       <= ST_IDLE;
            o_frame_err <= 1'b1;
          end else if (sclk_rise) begin
            cmd_sr <= cmd_next[6:0];
            if (bit_cnt == 5'd7) begin
              state     <= ST_DATA;
              bit_cnt   <= '0;
              rx_sr     <= '0;
              op_q      <= cmd_next[7:6];
              idx_q     <= idx_next;
              addr_ok_q <= addr_ok_next;
              tx_sr     <= rd_val;
              // Remember the pointer so an aborted data phase can put it back.
              ptr_prev  <= o_reg_pointer;
              if (cmd_next[7:6] != OP_COMMIT) begin
                if (addr_ok_next) begin
                  o_reg_pointer <= idx_next;
                end else begin
                  o_addr_err <= 1'b1;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        ST_DATA: begin
          if (cs_rise) begin
            state         <= ST_IDLE;
            o_frame_err   <= 1'b1;
            o_miso        <= 1'b0;
            o_reg_pointer <= ptr_prev;
          end else if (sclk_rise) begin
            rx_sr <= data_next;
            if (bit_cnt == 5'(REG_W - 1)) begin
              state  <= ST_DONE;
              o_miso <= 1'b0;
              if (op_q == OP_WR_SHD && addr_ok_q) begin
                shadow[idx_q] <= data_next;
              end
              if (op_q == OP_COMMIT) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                  active[k] <= shadow[k];
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else if (sclk_fall) begin
            o_miso <= tx_sr[REG_W-1];
            tx_sr  <= tx_sr << 1;
          end
        end

        ST_DONE: begin
          // Surplus sclk edges are ignored until cs_n rises.
          o_miso <= 1'b0;
          if (cs_rise) begin
            state <= ST_IDLE;
          end else if (cs_fall) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
            cmd_sr  <= '0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          o_miso <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_miso_oe <= 1'b0;
    end else begin
      o_miso_oe <= ~cs_sync[1];
    end
  end

endmodule

// File: tb/tb_spi_trim_bank.sv
`timescale 1ns/1ps
module tb_spi_trim_bank;
  localparam int N    = 8;
  localparam int W    = 8;
  localparam int FR   = 8 + W;
  localparam int PW   = (N > 1) ? $clog2(N) : 1;
  localparam int HALF = 8;
  localparam logic [W-1:0] RT = W'(16'hA55A);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk  = 1'b0;
  logic cs_n  = 1'b1;
  logic mosi  = 1'b0;
  logic o_miso, o_miso_oe, o_frame_err, o_addr_err;
  logic [N*W-1:0] o_trim;
  logic [PW-1:0]  o_reg_pointer;

  spi_trim_bank #(.NUM_REGS(N), .REG_W(W), .RESET_TRIM(RT)) dut (
    .clk(clk), .rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe), .o_trim(o_trim),
    .o_reg_pointer(o_reg_pointer), .o_frame_err(o_frame_err), .o_addr_err(o_addr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ae_cnt = 0;
  int miso_bad = 0;
  int idle_bad = 0;
  logic [N*W-1:0] trim_h [5];

  always @(negedge clk) begin
    if (o_frame_err === 1'b1) fe_cnt++;
    if (o_addr_err === 1'b1) ae_cnt++;
  end

  // Reference model: register contents and pointer as the master sees them
  logic [W-1:0] m_shadow [N];
  logic [W-1:0] m_active [N];
  int m_ptr;

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = RT;
      m_active[k] = RT;
    end
    m_ptr = 0;
  endtask

  function automatic logic [N*W-1:0] m_trim();
    logic [N*W-1:0] t;
    t = '0;
    for (int k = 0; k < N; k++) t[k*W +: W] = m_active[k];
    return t;
  endfunction

  // One SPI bit: MOSI set while sclk low, MISO sampled just before the rise,
  // o_trim recorded on the 4 clk cycles after the rise.
  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    repeat (HALF) @(negedge clk);
    m = o_miso;
    sclk = 1'b1;
    trim_h[0] = o_trim;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      trim_h[k] = o_trim;
    end
    repeat (HALF - 4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input logic [W-1:0] wd,
                          input int nbits, output logic [W-1:0] rx);
    logic [FR-1:0] sh;
    logic m, b;
    sh = {cmd, wd};
    rx = '0;
    @(negedge clk);
    if (o_miso !== 1'b0 || o_miso_oe !== 1'b0) idle_bad++;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    if (o_miso_oe !== 1'b1) idle_bad++;
    for (int i = 0; i < nbits; i++) begin
      if (i < FR) b = sh[FR-1-i];
      else b = 1'($urandom_range(0, 1));
      spi_bit(b, m);
      if (i >= 8 && i < FR) rx = (rx << 1) | W'(m);
      else if (i >= FR && m !== 1'b0) miso_bad++;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Runs one frame and advances the model by the frame-level rules.
  task automatic run_frame(input logic [7:0] cmd, input logic [W-1:0] wd, input int nbits,
                           output logic [W-1:0] rx_act, output logic [W-1:0] rx_exp,
                           output int fe_d, output int ae_d, output int fe_exp, output int ae_exp);
    int fe0, ae0, addr;
    logic [1:0] op;
    bit valid;
    op = cmd[7:6];
    addr = int'(cmd[5:0]);
    valid = (addr < N);
    fe0 = fe_cnt;
    ae0 = ae_cnt;
    spi_xfer(cmd, wd, nbits, rx_act);
    fe_d = fe_cnt - fe0;
    ae_d = ae_cnt - ae0;
    rx_exp = '0;
    fe_exp = (nbits < FR) ? 1 : 0;
    ae_exp = (nbits >= 8 && op != 2'b10 && !valid) ? 1 : 0;
    if (nbits >= FR) begin
      case (op)
        2'b00: if (valid) begin rx_exp = m_active[addr]; m_ptr = addr; end
        2'b01: if (valid) begin m_shadow[addr] = wd; m_ptr = addr; end
        2'b10: for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
        default: if (valid) begin rx_exp = m_shadow[addr]; m_ptr = addr; end
      endcase
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    n_vec++; if (o_trim !== {N{RT}}) begin n_err++; $display("FAIL reset_trim got %h want %h", o_trim, {N{RT}}); end
    n_vec++; if (o_reg_pointer !== '0) begin n_err++; $display("FAIL reset_ptr got %0d want 0", o_reg_pointer); end
    n_vec++; if (o_miso !== 1'b0 || o_miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_miso got %b/%b want 0/0", o_miso, o_miso_oe); end
    n_vec++; if (o_frame_err !== 1'b0 || o_addr_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b/%b want 0/0", o_frame_err, o_addr_err); end
    rst_n = 1'b1;
    m_reset();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_shadow_read();
    logic [W-1:0] ra, re;
    int fd, ad, fx, ax, a;
    a = (N > 3) ? 3 : N - 1;
    run_frame({2'b01, 6'(a)}, W'(8'h41), FR, ra, re, fd, ad, fx, ax);
    n_vec++; if (o_trim !== m_trim()) begin n_err++; $display("FAIL shr_trim_after_write got %h want %h", o_trim, m_trim()); end
    run_frame({2'b00, 6'(a)}, '0, FR, ra, re, fd, ad, fx, ax);
    n_vec++; if (ra !== re) begin n_err++; $display("FAIL shr_read_active got %h want %h", ra, re); end
    run_frame({2'b11, 6'(a)}, '0, FR, ra, re, fd, ad, fx, ax);
    n_vec++; if (ra !== re) begin n_err++; $display("FAIL shr_read_shadow got %h want %h", ra, re); end
    n_vec++; if (o_trim !== m_trim()) begin n_err++; $display("FAIL shr_trim_final got %h want %h", o_trim, m_trim()); end
    n_vec++; if (o_reg_pointer !== PW'(m_ptr)) begin n_err++; $display("FAIL shr_ptr got %0d want %0d", o_reg_pointer, m_ptr); end
  endtask

  task automatic test_commit();
    logic [W-1:0] ra, re;
    logic [N*W-1:0] old;
    int fd, ad, fx, ax, nchg;
    run_frame({2'b01, 6'(2 % N)}, W'(8'hA5), FR, ra, re, fd, ad, fx, ax);
    run_frame({2'b01, 6'(N - 1)}, W'(8'h3C), FR, ra, re, fd, ad, fx, ax);
    old = m_trim();
    n_vec++; if (o_trim !== old) begin n_err++; $display("FAIL cmt_before got %h want %h", o_trim, old); end
    run_frame({2'b10, 6'd5}, W'($urandom), FR, ra, re, fd, ad, fx, ax);
    nchg = 0;
    for (int k = 1; k < 5; k++) if (trim_h[k] !== trim_h[k-1]) nchg++;
    n_vec++; if (trim_h[4] !== m_trim()) begin n_err++; $display("FAIL cmt_within_4clk got %h want %h", trim_h[4], m_trim()); end
    n_vec++; if (nchg !== 1) begin n_err++; $display("FAIL cmt_same_cycle got %0d changes want 1", nchg); end
    n_vec++; if (o_trim !== m_trim()) begin n_err++; $display("FAIL cmt_trim got %h want %h", o_trim, m_trim()); end
    n_vec++; if (o_reg_pointer !== PW'(m_ptr)) begin n_err++; $display("FAIL cmt_ptr got %0d want %0d", o_reg_pointer, m_ptr); end
    n_vec++; if (ad !== 0) begin n_err++; $display("FAIL cmt_no_addr_err got %0d want 0", ad); end
  endtask

  task automatic test_abort();
    logic [W-1:0] ra, re;
    int fd, ad, fx, ax, a;
    a = (N > 1) ? 1 : 0;
    run_frame({2'b01, 6'(a)}, ~m_shadow[a], 11, ra, re, fd, ad, fx, ax);
    n_vec++; if (fd !== fx) begin n_err++; $display("FAIL abort_frame_err got %0d want %0d", fd, fx); end
    n_vec++; if (ad !== ax) begin n_err++; $display("FAIL abort_addr_err got %0d want %0d", ad, ax); end
    n_vec++; if (o_reg_pointer !== PW'(m_ptr)) begin n_err++; $display("FAIL abort_ptr got %0d want %0d", o_reg_pointer, m_ptr); end
    run_frame({2'b11, 6'(a)}, '0, FR, ra, re, fd, ad, fx, ax);
    n_vec++; if (ra !== re) begin n_err++; $display("FAIL abort_shadow_kept got %h want %h", ra, re); end
    n_vec++; if (o_trim !== m_trim()) begin n_err++; $display("FAIL abort_trim got %h want %h", o_trim, m_trim()); end
    run_frame({2'b01, 6'(a)}, W'(8'h96), FR, ra, re, fd, ad, fx, ax);
    run_frame({2'b11, 6'(a)}, '0, FR, ra, re, fd, ad, fx, ax);
    n_vec++; if (ra !== re || fd !== 0) begin n_err++; $display("FAIL abort_next_frame got %h/%0d want %h/0", ra, fd, re); end
  endtask

  task automatic test_addr_err();
    logic [W-1:0] ra, re;
    int fd, ad, fx, ax;
    logic [7:0] bad;
    bad = 8'(N + 1);
    run_frame({2'b01, bad[5:0]}, W'(8'h77), FR, ra, re, fd, ad, fx, ax);
    n_vec++; if (ad !== ax) begin n_err++; $display("FAIL aerr_write_pulse got %0d want %0d", ad, ax); end
    n_vec++; if (o_reg_pointer !== PW'(m_ptr)) begin n_err++; $display("FAIL aerr_ptr got %0d want %0d", o_reg_pointer, m_ptr); end
    run_frame({2'b11, bad[5:0]}, '0, FR, ra, re, fd, ad, fx, ax);
    n_vec++; if (ra !== re || ad !== ax) begin n_err++; $display("FAIL aerr_read got %h/%0d want %h/%0d", ra, ad, re, ax); end
    run_frame({2'b10, 6'd63}, '0, FR, ra, re, fd, ad, fx, ax);
    n_vec++; if (ad !== 0) begin n_err++; $display("FAIL aerr_commit got %0d want 0", ad); end
    n_vec++; if (o_trim !== m_trim()) begin n_err++; $display("FAIL aerr_trim got %h want %h", o_trim, m_trim()); end
  endtask

  task automatic test_extra_bits();
    logic [W-1:0] ra, re;
    int fd, ad, fx, ax, mb0;
    mb0 = miso_bad;
    run_frame({2'b01, 6'd0}, W'(8'hC3), FR + 4, ra, re, fd, ad, fx, ax);
    run_frame({2'b11, 6'd0}, '0, FR + 4, ra, re, fd, ad, fx, ax);
    n_vec++; if (ra !== re) begin n_err++; $display("FAIL extra_readback got %h want %h", ra, re); end
    n_vec++; if (miso_bad !== mb0) begin n_err++; $display("FAIL extra_miso_zero got %0d nonzero bits want 0", miso_bad - mb0); end
    n_vec++; if (fd !== 0) begin n_err++; $display("FAIL extra_frame_err got %0d want 0", fd); end
  endtask

  task automatic test_reset_mid();
    logic [FR-1:0] sh;
    logic m;
    logic [W-1:0] ra, re;
    int fe0, ae0, fd, ad, fx, ax;
    sh = {2'b01, 6'd0, ~RT};
    fe0 = fe_cnt;
    ae0 = ae_cnt;
    @(negedge clk); cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 8 + W / 2; i++) spi_bit(sh[FR-1-i], m);
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (o_trim !== {N{RT}} || o_reg_pointer !== '0) begin n_err++; $display("FAIL rmid_regs got %h/%0d want %h/0", o_trim, o_reg_pointer, {N{RT}}); end
    n_vec++; if (o_miso !== 1'b0 || o_miso_oe !== 1'b0) begin n_err++; $display("FAIL rmid_miso got %b/%b want 0/0", o_miso, o_miso_oe); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    // cs_n still low: a full frame without a new cs_n fall must do nothing
    for (int i = 0; i < FR; i++) spi_bit(sh[FR-1-i], m);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    n_vec++; if (fe_cnt !== fe0 || ae_cnt !== ae0) begin n_err++; $display("FAIL rmid_no_pulse got %0d/%0d want 0/0", fe_cnt - fe0, ae_cnt - ae0); end
    run_frame({2'b11, 6'd0}, '0, FR, ra, re, fd, ad, fx, ax);
    n_vec++; if (ra !== re) begin n_err++; $display("FAIL rmid_no_write got %h want %h", ra, re); end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, re, wd;
    int fd, ad, fx, ax, nb, r, addr;
    logic [1:0] op;
    for (int f = 0; f < 40; f++) begin
      op = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, N - 1));
      wd = W'($urandom);
      r = $urandom_range(0, 9);
      nb = FR;
      if (r == 0) nb = $urandom_range(1, FR - 1);
      else if (r == 1) nb = FR + $urandom_range(1, 4);
      run_frame({op, 6'(addr)}, wd, nb, ra, re, fd, ad, fx, ax);
      if (nb >= FR && (op == 2'b00 || op == 2'b11)) begin
        n_vec++; if (ra !== re) begin n_err++; $display("FAIL rnd_read f=%0d op=%0d a=%0d got %h want %h", f, op, addr, ra, re); end
      end
      n_vec++; if (fd !== fx || ad !== ax) begin n_err++; $display("FAIL rnd_err f=%0d got %0d/%0d want %0d/%0d", f, fd, ad, fx, ax); end
      n_vec++; if (o_trim !== m_trim()) begin n_err++; $display("FAIL rnd_trim f=%0d got %h want %h", f, o_trim, m_trim()); end
      n_vec++; if (o_reg_pointer !== PW'(m_ptr)) begin n_err++; $display("FAIL rnd_ptr f=%0d got %0d want %0d", f, o_reg_pointer, m_ptr); end
    end
    n_vec++; if (miso_bad !== 0 || idle_bad !== 0) begin n_err++; $display("FAIL rnd_idle_miso got %0d/%0d want 0/0", miso_bad, idle_bad); end
  endtask

  initial begin
    test_reset();
    test_shadow_read();
    test_commit();
    test_abort();
    test_addr_err();
    test_extra_bits();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
